// File: rtl/mux_deglitch.sv
// rtl/mux_deglitch.sv - deglitcher for a gate-level 2:1 mux output
// Synchronizes z_in, then accepts a level change only after it persists for STABLE_CYCLES edges.
module mux_deglitch #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             z_in,
    input  logic             en,
    output logic             q,
    output logic             rise,
    output logic             fall,
    output logic             busy,
    output logic [CNT_W-1:0] glitch_cnt
);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_PEND_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_PEND_LOW  = 2'd3
    } state_t;

    localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

    logic             s1_q;
    logic             s2_q;
    state_t           state_q;
    logic [3:0]       cnt_q;
    logic             q_q;
    logic             rise_q;
    logic             fall_q;
    logic             busy_q;
    logic [CNT_W-1:0] glitch_q;

    logic [3:0]       cnt_d;
    logic [CNT_W-1:0] glitch_d;

    assign cnt_d    = cnt_q + 4'd1;
    assign glitch_d = (&glitch_q) ? glitch_q : glitch_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            state_q  <= ST_LOW;
            cnt_q    <= 4'd0;
            q_q      <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            s1_q   <= z_in;
            s2_q   <= s1_q;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                ST_LOW: begin
                    cnt_q <= 4'd0;
                    if (en && s2_q) begin
                        // A one-cycle qualification window accepts immediately.
                        if (STABLE_N == 4'd1) begin
                            state_q <= ST_HIGH;
                            q_q     <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            state_q <= ST_PEND_HIGH;
                            cnt_q   <= 4'd1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_PEND_HIGH: begin
                    if (!en) begin
                        state_q <= ST_LOW;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                    end else if (s2_q) begin
                        if (cnt_d == STABLE_N) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= 4'd0;
                            busy_q  <= 1'b0;
                            q_q     <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end else begin
                        state_q  <= ST_LOW;
                        cnt_q    <= 4'd0;
                        busy_q   <= 1'b0;
                        glitch_q <= glitch_d;
                    end
                end
                ST_HIGH: begin
                    cnt_q <= 4'd0;
                    if (en && !s2_q) begin
                        if (STABLE_N == 4'd1) begin
                            state_q <= ST_LOW;
                            q_q     <= 1'b0;
                            fall_q  <= 1'b1;
                        end else begin
                            state_q <= ST_PEND_LOW;
                            cnt_q   <= 4'd1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_PEND_LOW: begin
                    if (!en) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                    end else if (!s2_q) begin
                        if (cnt_d == STABLE_N) begin
                            state_q <= ST_LOW;
                            cnt_q   <= 4'd0;
                            busy_q  <= 1'b0;
                            q_q     <= 1'b0;
                            fall_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end else begin
                        state_q  <= ST_HIGH;
                        cnt_q    <= 4'd0;
                        busy_q   <= 1'b0;
                        glitch_q <= glitch_d;
                    end
                end
                default: begin
                    state_q <= ST_LOW;
                    cnt_q   <= 4'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q          = q_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign busy       = busy_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_mux_deglitch.sv
// tb/tb_mux_deglitch.sv - randomized self-checking bench for mux_deglitch
// Two instances (STABLE_CYCLES 4 and 1) share stimulus and are compared to a run-length model.
module tb_mux_deglitch;

    logic clk;
    logic rst_n;
    logic z_in;
    logic en;

    logic       q0, rise0, fall0, busy0;
    logic [7:0] gc0;
    logic       q1, rise1, fall1, busy1;
    logic [7:0] gc1;

    logic [11:0] got [2];
    assign got[0] = {q0, rise0, fall0, busy0, gc0};
    assign got[1] = {q1, rise1, fall1, busy1, gc1};

    int checks   = 0;
    int failures = 0;
    int tick_no  = 0;
    logic busy1_seen = 1'b0;

    mux_deglitch #(.STABLE_CYCLES(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .z_in(z_in), .en(en),
        .q(q0), .rise(rise0), .fall(fall0), .busy(busy0), .glitch_cnt(gc0)
    );

    mux_deglitch #(.STABLE_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .z_in(z_in), .en(en),
        .q(q1), .rise(rise1), .fall(fall1), .busy(busy1), .glitch_cnt(gc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an accepted change is a run of STABLE_CYCLES enabled edges on which
    // the synchronized level differs from q; a broken enabled run is one glitch.
    logic m_s1 [2];
    logic m_s2 [2];
    logic m_q [2];
    logic m_rise [2];
    logic m_fall [2];
    int   m_run [2];
    int   m_gc [2];

    function automatic int sc_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_q[i] = 1'b0;
            m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_run[i] = 0; m_gc[i] = 0;
        end
    endfunction

    function automatic void model_edge(input logic z, input logic e);
        for (int i = 0; i < 2; i++) begin
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (e && (m_s2[i] != m_q[i])) begin
                m_run[i]++;
                if (m_run[i] == sc_of(i)) begin
                    m_q[i] = ~m_q[i];
                    if (m_q[i]) m_rise[i] = 1'b1;
                    else        m_fall[i] = 1'b1;
                    m_run[i] = 0;
                end
            end else begin
                if (e && m_run[i] > 0 && m_gc[i] < 255) m_gc[i]++;
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = z;
        end
    endfunction

    function automatic logic [11:0] exp_vec(input int i);
        return {m_q[i], m_rise[i], m_fall[i], (m_run[i] != 0), 8'(m_gc[i])};
    endfunction

    task automatic tick(input logic z, input logic e);
        z_in = z;
        en   = e;
        @(posedge clk);
        model_edge(z, e);
        @(negedge clk);
        tick_no++;
        if (busy1) busy1_seen = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; z_in = 1'b0; en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got[i] !== 12'h000) begin
                failures++;
                $display("FAIL reset_state dut%0d got=%h exp=%h", i, got[i], 12'h000);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_hold_high();
        logic [11:0] e0, e1;
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, 1'b1);
            e0 = {(k >= 5), (k == 5), 1'b0, (k >= 2 && k <= 4), 8'd0};
            e1 = {(k >= 2), (k == 2), 1'b0, 1'b0, 8'd0};
            checks += 2;
            if (got[0] !== e0) begin
                failures++;
                $display("FAIL hold_high_sc4 edge=%0d got=%h exp=%h", k, got[0], e0);
            end
            if (got[1] !== e1) begin
                failures++;
                $display("FAIL hold_high_sc1 edge=%0d got=%h exp=%h", k, got[1], e1);
            end
        end
    endtask

    task automatic test_short_pulse();
        int busy_hits = 0;
        int gc_start;
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b1);
        gc_start = int'(gc0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b1);
            if (busy0) busy_hits++;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got[i] !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL short_pulse dut%0d t=%0d got=%h exp=%h", i, tick_no, got[i], exp_vec(i));
                end
            end
        end
        checks++;
        if (q0 !== 1'b0 || busy_hits == 0 || int'(gc0) != gc_start + 1) begin
            failures++;
            $display("FAIL short_pulse_glitch q=%b busy_hits=%0d gc=%0d exp q=0 busy_hits>0 gc=%0d",
                     q0, busy_hits, gc0, gc_start + 1);
        end
    endtask

    task automatic test_random();
        logic z = 1'b0;
        logic e;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) z = ~z;
            e = ($urandom_range(0, 9) != 0);
            tick(z, e);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got[i] !== exp_vec(i) || (got[i][10] && got[i][9])) begin
                    failures++;
                    $display("FAIL random dut%0d t=%0d got=%h exp=%h", i, tick_no, got[i], exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 8; k++) tick(1'b0, 1'b1);
        for (int g = 0; g < 300; g++) begin
            tick(1'b1, 1'b1);
            for (int k = 0; k < 3; k++) tick(1'b0, 1'b1);
            checks++;
            if (got[0] !== exp_vec(0)) begin
                failures++;
                $display("FAIL saturation_track g=%0d got=%h exp=%h", g, got[0], exp_vec(0));
            end
        end
        checks++;
        if (gc0 !== 8'd255) begin
            failures++;
            $display("FAIL saturation_value got=%0d exp=255", gc0);
        end
    endtask

    task automatic test_en_freeze();
        int lat = 0;
        int nfall = 0;
        for (int k = 0; k < 10; k++) tick(1'b1, 1'b1);
        checks++;
        if (q0 !== 1'b1) begin
            failures++;
            $display("FAIL en_freeze_setup got q=%b exp q=1", q0);
        end
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (q0 !== 1'b1 || fall0 !== 1'b0 || got[0] !== exp_vec(0)) begin
                failures++;
                $display("FAIL en_freeze_hold k=%0d got=%h exp=%h", k, got[0], exp_vec(0));
            end
        end
        for (int k = 1; k <= 20; k++) begin
            tick(1'b0, 1'b1);
            if (fall0) nfall++;
            if (q0 === 1'b0 && lat == 0) lat = k;
            checks++;
            if (got[0] !== exp_vec(0)) begin
                failures++;
                $display("FAIL en_release k=%0d got=%h exp=%h", k, got[0], exp_vec(0));
            end
        end
        checks++;
        if (lat < 4 || lat > 5 || nfall != 1) begin
            failures++;
            $display("FAIL en_release_latency got lat=%0d falls=%0d exp lat=4..5 falls=1", lat, nfall);
        end
    endtask

    task automatic test_reset_mid_pend();
        for (int k = 0; k < 8; k++) tick(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b1);
        checks++;
        if (busy0 !== 1'b1) begin
            failures++;
            $display("FAIL mid_pend_busy got=%b exp=1", busy0);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got[i] !== 12'h000) begin
                failures++;
                $display("FAIL async_reset dut%0d got=%h exp=%h", i, got[i], 12'h000);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got[i] !== exp_vec(i) || got[i][7:0] !== 8'd0) begin
                    failures++;
                    $display("FAIL post_reset dut%0d k=%0d got=%h exp=%h", i, k, got[i], exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_sc1_no_busy();
        checks++;
        if (busy1_seen !== 1'b0) begin
            failures++;
            $display("FAIL sc1_busy got=%b exp=0", busy1_seen);
        end
    endtask

    initial begin
        test_reset();
        test_hold_high();
        test_short_pulse();
        test_random();
        test_saturation();
        test_en_freeze();
        test_reset_mid_pend();
        test_sc1_no_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_deglitch.md
MUX_DEGLITCH -- requirements
Module: mux_deglitch

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, legal range 1..15: consecutive sampled cycles an input change must persist before it is accepted.
REQ-002 SHALL have parameter CNT_W, default 8, the width of the rejected-glitch counter.
REQ-003 SHALL use exactly one clock and a reset that is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1 bit, rising-edge clock for all state.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port z_in, input, 1 bit, asynchronous, possibly glitching output of the upstream gate-level 2:1 mux.
REQ-007 SHALL have port en, input, 1 bit, synchronous qualifier; 0 freezes acceptance of changes.
REQ-008 SHALL have port q, output, 1 bit, deglitched registered level.
REQ-009 SHALL have port rise, output, 1 bit, one-cycle pulse when q goes 0->1.
REQ-010 SHALL have port fall, output, 1 bit, one-cycle pulse when q goes 1->0.
REQ-011 SHALL have port busy, output, 1 bit, high while a pending change is being qualified.
REQ-012 SHALL have port glitch_cnt, output, CNT_W bits, saturating count of rejected pending changes.

Function
REQ-013 SHALL pass z_in through a 2-flop synchronizer (s1, s2); no other logic SHALL sample z_in directly.
REQ-014 SHALL implement a 4-state FSM: LOW, PEND_HIGH, HIGH, PEND_LOW; q = 1 in HIGH and PEND_LOW, and q = 0 in LOW and PEND_HIGH.
REQ-015 SHALL keep a 4-bit stability counter cnt, cleared on every state transition.
REQ-016 In LOW with en=1 and s2=1, the FSM SHALL move to PEND_HIGH with cnt=1; HIGH with s2=0 SHALL move to PEND_LOW with cnt=1 symmetrically.
REQ-017 In PEND_x, each edge with s2 equal to the pending value SHALL increment cnt; when the incremented value equals STABLE_CYCLES, the FSM SHALL enter HIGH or LOW and q SHALL toggle on that same edge.
REQ-018 With STABLE_CYCLES=1, the FSM SHALL pass from LOW directly to HIGH (and HIGH directly to LOW), without entering a PEND state.
REQ-019 Latency: if edge e0 is the first edge at which s1 captures a new stable level, q SHALL change at edge e0+STABLE_CYCLES+1.
REQ-020 In PEND_x, if s2 reverts to the current q, the FSM SHALL return to the stable state, q SHALL remain unchanged, and glitch_cnt SHALL increment by 1.
REQ-021 glitch_cnt SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-022 rise and fall SHALL be registered, high for exactly the one cycle following the edge at which q toggles, and never high simultaneously.
REQ-023 busy SHALL be 1 exactly when the FSM is in PEND_HIGH or PEND_LOW.
REQ-024 en=0 SHALL force the FSM back to the current stable state with cnt=0 on the next edge, with no pulses and no glitch_cnt increment; the synchronizer keeps running.
REQ-025 When en rises, qualification SHALL restart from cnt=0 using the current s2.

Reset
REQ-026 rst_n=0 SHALL immediately set s1=0, s2=0, FSM=LOW, cnt=0, q=0, rise=0, fall=0, busy=0 and glitch_cnt=0, independent of clk.
REQ-027 Reset asserted mid-qualification SHALL discard the pending change without counting a glitch.
REQ-028 After rst_n deasserts, the first state update SHALL occur at the first rising clk edge.

Verification (STABLE_CYCLES=4 unless stated)
REQ-029 Hold z_in=1 from edge e0 -> q=1 and rise=1 after e5; busy=1 for cycles e2..e4; glitch_cnt=0.
REQ-030 A 2-cycle z_in=1 pulse, then z_in=0 -> q stays 0, busy pulses, and glitch_cnt=1.
REQ-031 Apply 300 short glitches -> glitch_cnt=255 and holds there (saturation).
REQ-032 q=1, then z_in=0 while en=0 for 10 cycles -> q stays 1 and no fall pulse; en=1 -> q=0 four or five cycles later, depending on edge alignment per REQ-025, with one fall pulse.
REQ-033 Assert rst_n=0 during PEND_HIGH between edges -> all outputs drop to 0 immediately; glitch_cnt=0 after reset release.
REQ-034 STABLE_CYCLES=1, z_in step at e0 -> q changes at e2, and busy never asserts.
